// File: rtl/alu_stack_sequencer.sv
// Operand-stack sequencer for the combinational 8-bit ALU of the stack processor.
// Accepts PUSH/POP/EXEC/CLEAR over valid/ready and runs EXEC as OPND -> CALC -> WB,
// writing the ALU result back as the new top of stack.
// Optional feature: define ALU_SEQ_ZFLAG_EN to add the zflag output (zero result of last WB).
module alu_stack_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DW    = 8
) (
  input  logic                      CLK,
  input  logic                      reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_kind,
  input  logic [1:0]                cmd_op,
  input  logic [DW-1:0]             cmd_imm,
  output logic [1:0]                alu_op,
  output logic [DW-1:0]             alu_a,
  output logic [DW-1:0]             alu_b,
  input  logic [DW-1:0]             alu_rslt,
  output logic [DW-1:0]             tos,
  output logic [$clog2(DEPTH):0]    depth,
`ifdef ALU_SEQ_ZFLAG_EN
  output logic                      zflag,
`endif
  output logic                      busy,
  output logic                      err
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned DepthW = AW + 1;

  localparam logic [1:0] KindPush  = 2'b00;
  localparam logic [1:0] KindPop   = 2'b01;
  localparam logic [1:0] KindExec  = 2'b10;
  localparam logic [1:0] KindClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StOpnd, StCalc, StWb} state_e;

  state_e              state_q, state_d;
  logic [DepthW-1:0]   depth_q, depth_d;
  logic                err_q, err_d;
  logic [DW-1:0]       a_q, a_d, b_q, b_d, rslt_q, rslt_d;
  logic [1:0]          op_q, op_d;
`ifdef ALU_SEQ_ZFLAG_EN
  logic                zflag_q, zflag_d;
`endif

  logic [DW-1:0]       mem_q [DEPTH];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [DW-1:0]       mem_wdata;

  logic [AW-1:0]       wr_idx, tos_idx, nos_idx;
  logic                accept, full, empty;

  assign wr_idx  = AW'(depth_q);
  assign tos_idx = AW'(depth_q - DepthW'(1));
  assign nos_idx = AW'(depth_q - DepthW'(2));
  assign full    = (depth_q == DepthW'(DEPTH));
  assign empty   = (depth_q == '0);

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;
  assign depth     = depth_q;
  assign err       = err_q;
  assign tos       = empty ? '0 : mem_q[tos_idx];
`ifdef ALU_SEQ_ZFLAG_EN
  assign zflag     = zflag_q;
`endif

  // ALU operands are only presented during CALC; zero otherwise.
  assign alu_op = (state_q == StCalc) ? op_q : 2'b00;
  assign alu_a  = (state_q == StCalc) ? a_q  : '0;
  assign alu_b  = (state_q == StCalc) ? b_q  : '0;

  // Next-state and datapath decode for the command FSM.
  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    err_d     = err_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rslt_d    = rslt_q;
`ifdef ALU_SEQ_ZFLAG_EN
    zflag_d   = zflag_q;
`endif
    mem_we    = 1'b0;
    mem_waddr = wr_idx;
    mem_wdata = cmd_imm;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_kind)
            KindPush: begin
              if (full) begin
                err_d = 1'b1;
              end else begin
                mem_we  = 1'b1;
                depth_d = depth_q + DepthW'(1);
              end
            end
            KindPop: begin
              if (empty) err_d = 1'b1;
              else       depth_d = depth_q - DepthW'(1);
            end
            KindExec: begin
              if (depth_q < DepthW'(2)) begin
                err_d = 1'b1;
              end else begin
                op_d    = cmd_op;
                state_d = StOpnd;
              end
            end
            KindClear: begin
              depth_d = '0;
              err_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      StOpnd: begin
        a_d     = mem_q[nos_idx];
        b_d     = mem_q[tos_idx];
        state_d = StCalc;
      end
      StCalc: begin
        rslt_d  = alu_rslt;
        state_d = StWb;
      end
      StWb: begin
        // Result replaces NOS; TOS is consumed.
        mem_we    = 1'b1;
        mem_waddr = nos_idx;
        mem_wdata = rslt_q;
        depth_d   = depth_q - DepthW'(1);
`ifdef ALU_SEQ_ZFLAG_EN
        zflag_d   = (rslt_q == '0);
`endif
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= StIdle;
      depth_q <= '0;
      err_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      rslt_q  <= '0;
`ifdef ALU_SEQ_ZFLAG_EN
      zflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rslt_q  <= rslt_d;
`ifdef ALU_SEQ_ZFLAG_EN
      zflag_q <= zflag_d;
`endif
    end
  end

  // Stack storage; contents are don't-care after reset, but reset blocks a pending write.
  always_ff @(posedge CLK) begin
    if (reset_n && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_alu_stack_sequencer.sv
// Directed bench for alu_stack_sequencer; supplies a reference ALU on the alu_* port.
module tb_alu_stack_sequencer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 8;

  logic                   CLK = 1'b0;
  logic                   reset_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [1:0]             cmd_kind, cmd_op;
  logic [DW-1:0]          cmd_imm;
  logic [1:0]             alu_op;
  logic [DW-1:0]          alu_a, alu_b, alu_rslt, tos;
  logic [$clog2(DEPTH):0] depth;
  logic                   busy, err;
`ifdef ALU_SEQ_ZFLAG_EN
  logic                   zflag;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  always #5 CLK = ~CLK;

  alu_stack_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_kind  (cmd_kind),
    .cmd_op    (cmd_op),
    .cmd_imm   (cmd_imm),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_rslt  (alu_rslt),
    .tos       (tos),
    .depth     (depth),
`ifdef ALU_SEQ_ZFLAG_EN
    .zflag     (zflag),
`endif
    .busy      (busy),
    .err       (err)
  );

  // Reference ALU: ADD, SUB (a-b), SL/SR of a by b; shifts of 8 or more give 0.
  always_comb begin
    alu_rslt = '0;
    case (alu_op)
      2'd0: alu_rslt = alu_a + alu_b;
      2'd1: alu_rslt = alu_a - alu_b;
      2'd2: alu_rslt = (alu_b >= 8) ? 8'h00 : alu_a << alu_b;
      2'd3: alu_rslt = (alu_b >= 8) ? 8'h00 : alu_a >> alu_b;
      default: alu_rslt = '0;
    endcase
  end

  always @(posedge CLK) if (cmd_valid && cmd_ready && reset_n) n_acc <= n_acc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a command and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] kind, input logic [1:0] op, input logic [7:0] imm);
    bit done = 0;
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_op    = op;
    cmd_imm   = imm;
    for (int i = 0; i < 20 && !done; i++) begin
      done = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic push(input logic [7:0] v);
    send(2'b00, 2'b00, v);
  endtask

  // EXEC with the expected CALC operands and post-writeback stack state.
  task automatic exec(input string tag, input logic [1:0] op, input logic [7:0] ea,
                      input logic [7:0] eb, input logic [7:0] etos, input int edep);
    send(2'b10, op, 8'h00);
    check({tag, "_opnd_ready"}, 32'(cmd_ready), 32'd0);
    tick();
    check({tag, "_calc_op"}, 32'(alu_op), 32'(op));
    check({tag, "_calc_a"}, 32'(alu_a), 32'(ea));
    check({tag, "_calc_b"}, 32'(alu_b), 32'(eb));
    tick();
    check({tag, "_wb_busy"}, 32'(busy), 32'd1);
    check({tag, "_wb_alu_a"}, 32'(alu_a), 32'd0);
    tick();
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_tos"}, 32'(tos), 32'(etos));
    check({tag, "_depth"}, 32'(depth), 32'(edep));
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_kind = 2'b00; cmd_op = 2'b00; cmd_imm = '0;
    tick(); tick();
    reset_n = 1'b1;
    // 1: reset state, then ADD
    check("rst_depth", 32'(depth), 32'd0);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_alu", {22'd0, alu_op, alu_a}, 32'd0);
`ifdef ALU_SEQ_ZFLAG_EN
    check("rst_zflag", 32'(zflag), 32'd0);
`endif
    push(8'd5); push(8'd3);
    check("push2_tos", 32'(tos), 32'd3);
    check("push2_depth", 32'(depth), 32'd2);
    exec("add", 2'd0, 8'd5, 8'd3, 8'd8, 1);
    // 2: SUB wraps
    send(2'b11, 2'b00, 8'h00);
    push(8'd3); push(8'd5);
    exec("sub", 2'd1, 8'd3, 8'd5, 8'hFE, 1);
`ifdef ALU_SEQ_ZFLAG_EN
    check("sub_zflag", 32'(zflag), 32'd0);
`endif
    // 3: shifts, including amount >= 8
    send(2'b11, 2'b00, 8'h00);
    push(8'h81); push(8'd1);
    exec("sl", 2'd2, 8'h81, 8'd1, 8'h02, 1);
    push(8'd9);
    exec("sr", 2'd3, 8'h02, 8'd9, 8'h00, 1);
`ifdef ALU_SEQ_ZFLAG_EN
    check("sr_zflag", 32'(zflag), 32'd1);
    push(8'd4);
    check("push_keeps_zflag", 32'(zflag), 32'd1);
`endif
    // 4: overflow, CLEAR, underflow
    send(2'b11, 2'b00, 8'h00);
    for (int i = 1; i <= DEPTH + 1; i++) push(8'(i));
    check("ovf_depth", 32'(depth), 32'(DEPTH));
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_tos", 32'(tos), 32'(DEPTH));
    send(2'b11, 2'b00, 8'h00);
    check("clr_depth", 32'(depth), 32'd0);
    check("clr_err", 32'(err), 32'd0);
    check("clr_tos", 32'(tos), 32'd0);
    send(2'b01, 2'b00, 8'h00);
    check("unf_err", 32'(err), 32'd1);
    check("unf_depth", 32'(depth), 32'd0);
    // 5: EXEC with one operand, then command held across a busy EXEC
    send(2'b11, 2'b00, 8'h00);
    push(8'd7);
    send(2'b10, 2'b00, 8'h00);
    check("short_err", 32'(err), 32'd1);
    check("short_depth", 32'(depth), 32'd1);
    check("short_busy", 32'(busy), 32'd0);
    check("short_tos", 32'(tos), 32'd7);
    push(8'd2);
    n_acc = 0;
    send(2'b10, 2'b00, 8'h00);
    send(2'b00, 2'b00, 8'h77);
    tick(); tick();
    check("held_accepts", 32'(n_acc), 32'd2);
    check("held_depth", 32'(depth), 32'd2);
    check("held_tos", 32'(tos), 32'h77);
    send(2'b01, 2'b00, 8'h00);
    check("held_exec_result", 32'(tos), 32'd9);
    // 6: reset during CALC aborts writeback
    push(8'd1); push(8'd2);
    send(2'b10, 2'b00, 8'h00);
    tick();
    check("abort_in_calc", 32'(alu_b), 32'd2);
    reset_n = 1'b0;
    tick();
    check("abort_depth", 32'(depth), 32'd0);
    check("abort_tos", 32'(tos), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    tick();
    push(8'h10);
    check("post_abort_tos", 32'(tos), 32'h10);
    check("post_abort_depth", 32'(depth), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
